// File: rtl/dyn_array_reader_if.sv
// Bus bundle for dyn_array_reader.
//   slave  : the array itself (takes resize/write/read/stream requests,
//            drives read results, stream data and status)
//   master : the host/consumer side driving requests and accepting data
// Signals:
//   rsz_en/rsz_len            resize request and new length
//   wr_en/wr_idx/wr_data      element write
//   rd_en/rd_idx              random read request
//   rd_valid/rd_data/rd_oob   random read result (one cycle later)
//   start                     begin streaming elements 0..len-1
//   out_valid/out_ready       stream handshake
//   out_data/out_last         stream element and final-element marker
//   done                      single-cycle stream-complete pulse
//   len/busy                  current length, stream in progress
interface dyn_array_reader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
);
  logic             rsz_en;
  logic [LW-1:0]    rsz_len;
  logic             wr_en;
  logic [LW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [LW-1:0]    rd_idx;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_oob;
  logic             start;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             done;
  logic [LW-1:0]    len;
  logic             busy;

  modport slave (
    input  rsz_en, rsz_len, wr_en, wr_idx, wr_data, rd_en, rd_idx,
           start, out_ready,
    output rd_valid, rd_data, rd_oob, out_valid, out_data, out_last,
           done, len, busy
  );

  modport master (
    output rsz_en, rsz_len, wr_en, wr_idx, wr_data, rd_en, rd_idx,
           start, out_ready,
    input  rd_valid, rd_data, rd_oob, out_valid, out_data, out_last,
           done, len, busy
  );
endinterface

// File: rtl/dyn_array_reader.sv
// Register-backed variable-length array with random-access reads and a
// valid/ready streaming port.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dyn_array_reader_if.slave (see interface for signal list)
module dyn_array_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                rst_n,
  dyn_array_reader_if.slave  bus
);
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_len_snap;
  logic [LW-1:0]    r_ptr;
  logic             r_rd_valid;
  logic             r_rd_oob;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_done;

  logic             w_rd_in;
  logic             w_wr_in;
  logic             w_last;
  logic             w_streaming;
  logic [LW-1:0]    w_new_len;

  // Index checks against len guarantee idx < DEPTH, so the low AW bits
  // address the array without wrap.
  assign w_rd_in     = bus.rd_idx < r_len;
  assign w_wr_in     = bus.wr_idx < r_len;
  assign w_last      = r_ptr == (r_len_snap - 1'b1);
  assign w_streaming = r_state == STREAM;
  assign w_new_len   = (bus.rsz_len > DEPTH_L) ? DEPTH_L : bus.rsz_len;

  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_oob    = r_rd_oob;
  assign bus.out_valid = w_streaming;
  // Stream data follows the live array contents so writes to the current
  // element are visible while stalled.
  assign bus.out_data  = w_streaming ? r_mem[r_ptr[AW-1:0]] : '0;
  assign bus.out_last  = w_streaming && w_last;
  assign bus.done      = r_done;
  assign bus.len       = r_len;
  assign bus.busy      = w_streaming;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state    <= IDLE;
      r_len      <= '0;
      r_len_snap <= '0;
      r_ptr      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      // Reads sample pre-edge len and contents, so a same-cycle write or
      // resize is not visible to them.
      r_rd_valid <= bus.rd_en;
      r_rd_oob   <= bus.rd_en && !w_rd_in;
      r_rd_data  <= (bus.rd_en && w_rd_in) ? r_mem[bus.rd_idx[AW-1:0]] : '0;
      r_done     <= 1'b0;

      if (bus.rsz_en) begin
        // Resize wins over writes and aborts any stream without done.
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        r_len   <= w_new_len;
        r_state <= IDLE;
        r_ptr   <= '0;
      end else begin
        if (bus.wr_en && w_wr_in) r_mem[bus.wr_idx[AW-1:0]] <= bus.wr_data;

        case (r_state)
          IDLE: begin
            if (bus.start) begin
              if (r_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state    <= STREAM;
                r_ptr      <= '0;
                r_len_snap <= r_len;
              end
            end
          end
          STREAM: begin
            if (bus.out_ready) begin
              if (w_last) begin
                r_state <= IDLE;
                r_ptr   <= '0;
                r_done  <= 1'b1;
              end else begin
                r_ptr <= r_ptr + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/dyn_array_reader.md
Name: dyn_array_reader

Overview:
- Register-backed variable-length array, the read side of a writer/reader pair.
- Host side sets the length (resize clears all contents) and writes elements.
- Consumer side reads by random access (out-of-bounds reads return 0 with a flag) or streams elements 0..len-1 over a valid/ready handshake.
- Sits beside the dut as the hardware model of a dynamic-array buffer feeding a downstream consumer.

Parameters:
- WIDTH, 32, element width in bits.
- DEPTH, 16, maximum element count (≥2).
- LW, $clog2(DEPTH+1), width of length and index fields.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rsz_en  input  1  resize request, single-cycle.
- rsz_len  input  LW  new length, clamped to DEPTH.
- wr_en  input  1  element write.
- wr_idx  input  LW  write index.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  random-access read request.
- rd_idx  input  LW  read index.
- rd_valid  output  1  read result valid.
- rd_data  output  WIDTH  read result.
- rd_oob  output  1  read index was ≥ len.
- start  input  1  begin stream.
- out_valid  output  1  stream element valid.
- out_ready  input  1  consumer ready.
- out_data  output  WIDTH  stream element.
- out_last  output  1  final element of stream.
- done  output  1  stream complete, single-cycle pulse.
- len  output  LW  current length.
- busy  output  1  stream in progress.

Behaviour:
- Reset (async assert, sync release): all entries 0, len=0, state IDLE, all outputs 0.

Resize:
- On rsz_en, len <= min(rsz_len, DEPTH) and all DEPTH entries <= 0 in the same edge.
- New contents are visible the next cycle.
- Resize has priority over a wr_en in the same cycle; that write is dropped.

Write:
- On wr_en with wr_idx < len, mem[wr_idx] <= wr_data.
- wr_idx ≥ len is silently ignored.

Random read:
- Latency 1: rd_valid is high the cycle after rd_en.
- rd_data = mem[rd_idx] if rd_idx < len, else 0 with rd_oob=1.
- len used for the check is the pre-edge value.
- Read and write to the same index in the same cycle return the old data.
- rd_valid and rd_oob are 0 when no read is returning.

Stream FSM:
- IDLE: on start with len>0, go to STREAM; ptr=0; out_valid=1 next cycle.
- IDLE: on start with len=0, stay IDLE; done pulses next cycle.
- STREAM:
  - out_data = mem[ptr].
  - out_last = (ptr == len_snap-1), where len_snap is len captured at start.
  - On out_valid & out_ready: if out_last, go to IDLE, pulse done next cycle, out_valid=0; else ptr++.
  - out_valid and out_data are held stable while out_ready=0.
  - Writes during STREAM are allowed; out_data reflects current mem[ptr].
- start while busy: ignored.
- rsz_en during STREAM: stream aborts, state IDLE, out_valid=0 next cycle, no done pulse.
- busy = (state==STREAM).
- Reset mid-stream: immediate return to IDLE with all outputs 0.

Test Plan:
- Reset, rsz_len=3, write 1,2,3 at idx 0..2, read idx 0..2 -> rd_data 1,2,3 one cycle after each rd_en, rd_oob=0.
- len=3, rd_idx=40 (DEPTH=64 build, or rd_idx=15 at DEPTH=16) -> rd_valid=1, rd_data=0, rd_oob=1; a write to idx 5 is ignored, and reading idx 5 after resize to 8 returns 0.
- Contents 1,2,3, resize to 2 -> len=2, reads idx 0,1 return 0,0, idx 2 oob; resize and write in the same cycle -> write dropped.
- Contents 1,2,3, start, out_ready toggled 1,0,0,1,1 -> out_data sequence 1,2,3; data held during stalls; out_last only with 3; done pulses once after the 3 handshake; busy drops.
- start with len=0 -> no out_valid, done pulse next cycle; start during stream -> no restart.
- Mid-stream resize (after element 1 accepted) -> out_valid=0 next cycle, no done, len updated; rst_n asserted mid-stream -> outputs 0 asynchronously.
